// File: rtl/pll_lock_reset_ctrl_if.sv
// Avalon-MM slave bus bundle for pll_lock_reset_ctrl.
//   avs_address   : word address (8 registers)
//   avs_read      : read strobe, data returned one cycle later
//   avs_write     : write strobe
//   avs_writedata : write data
//   avs_readdata  : registered read data
// master modport drives the bus (CPU / testbench), slave modport is the block.
interface pll_lock_reset_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/pll_lock_reset_ctrl.sv
// Per-channel PLL reset sequencer and lock monitor behind one Avalon-MM slave.
// Each channel runs IDLE -> RESET (timed reset pulse) -> WAIT (lock
// qualification with timeout) -> UP, falling back to IDLE on loss of lock
// (recorded in STICKY) or parking in FAULT on timeout.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   avs          : Avalon-MM slave (pll_lock_reset_ctrl_if.slave)
//   lock_in      : asynchronous PLL locked inputs, one per channel
//   rst_out      : active-high PLL reset outputs, one per channel
//   irq          : level interrupt, only when PLL_LOCK_IRQ_EN is defined
//
// Register map (word address):
//   0 STATUS RO, 1 STICKY W1C, 2 FAULT RO, 3 START WO, 4 RST_LEN RW [15:0],
//   5 LOCK_RAW RO, 6 IRQ_MASK RW (PLL_LOCK_IRQ_EN only, else 0), 7 reads 0.
//
// Build option: define PLL_LOCK_IRQ_EN to add IRQ_MASK and the irq output.

// One channel's sequencer. rst_out/up/fault decode the state register;
// loss pulses for the cycle UP sees lock_s drop.
module pll_lock_ch #(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        lock_s,
  input  logic [15:0] rst_len,
  output logic        rst_out,
  output logic        up,
  output logic        fault,
  output logic        loss
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_WAIT, S_UP, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rcnt_q, rcnt_d;
  logic [7:0]    stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          stab_done, tmo_done;

  assign stab_done = lock_s && ((stab_q + 8'd1) == 8'(STABLE_CYCLES));
  assign tmo_done  = (tmo_q + TW'(1)) == TW'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= 16'd1;
      rcnt_q  <= '0;
      stab_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rcnt_q  <= rcnt_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rcnt_d  = rcnt_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    loss    = 1'b0;
    case (state_q)
      // rcnt_q counts RESET cycles already spent, starting at 1 on entry
      S_RESET: begin
        if (rcnt_q >= len_q) begin
          state_d = S_WAIT;
          stab_d  = '0;
          tmo_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        stab_d = lock_s ? stab_q + 8'd1 : '0;
        tmo_d  = tmo_q + TW'(1);
        // stable completion beats a coincident timeout
        if (stab_done)     state_d = S_UP;
        else if (tmo_done) state_d = S_FAULT;
      end
      S_UP: begin
        if (!lock_s) begin
          state_d = S_IDLE;
          loss    = 1'b1;
        end
      end
      default: ;
    endcase
    // START overrides everything; loss above still reports so STICKY sets
    if (start) begin
      state_d = S_RESET;
      rcnt_d  = 16'd1;
      len_d   = (rst_len == 16'd0) ? 16'd1 : rst_len;
      stab_d  = '0;
      tmo_d   = '0;
    end
  end

  assign rst_out = !(state_q == S_WAIT || state_q == S_UP);
  assign up      = (state_q == S_UP);
  assign fault   = (state_q == S_FAULT);
endmodule

module pll_lock_reset_ctrl #(
  parameter int N_CH           = 4,
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_lock_reset_ctrl_if.slave  avs,
  input  logic [N_CH-1:0]       lock_in,
  output logic [N_CH-1:0]       rst_out
`ifdef PLL_LOCK_IRQ_EN
  ,
  output logic                  irq
`endif
);
  logic [N_CH-1:0] sync1_q, lock_s_q;
  logic [N_CH-1:0] sticky_q, sticky_d;
  logic [15:0]     rst_len_q, rst_len_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [N_CH-1:0] start, up, fault, loss;
  logic            wr_sticky, wr_start, wr_len;
  logic            unused_wdata;

  assign wr_sticky = avs.avs_write && (avs.avs_address == 3'd1);
  assign wr_start  = avs.avs_write && (avs.avs_address == 3'd3);
  assign wr_len    = avs.avs_write && (avs.avs_address == 3'd4);
  assign start     = wr_start ? avs.avs_writedata[N_CH-1:0] : '0;
  // upper write-data bits have no destination for small N_CH
  assign unused_wdata = ^avs.avs_writedata;

`ifdef PLL_LOCK_IRQ_EN
  logic [N_CH-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
  logic            wr_mask;
  assign wr_mask = avs.avs_write && (avs.avs_address == 3'd6);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pll_lock_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start[i]),
      .lock_s (lock_s_q[i]),
      .rst_len(rst_len_q),
      .rst_out(rst_out[i]),
      .up     (up[i]),
      .fault  (fault[i]),
      .loss   (loss[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      lock_s_q  <= '0;
      sticky_q  <= '0;
      rst_len_q <= 16'(RST_CYCLES);
      rdata_q   <= '0;
    end else begin
      sync1_q   <= lock_in;
      lock_s_q  <= sync1_q;
      sticky_q  <= sticky_d;
      rst_len_q <= rst_len_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    // a loss in the same cycle as a W1C of that bit keeps the bit set
    sticky_d  = (sticky_q & ~(wr_sticky ? avs.avs_writedata[N_CH-1:0] : '0)) | loss;
    rst_len_d = wr_len ? avs.avs_writedata[15:0] : rst_len_q;
    rdata_d   = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        3'd0:    rdata_d[N_CH-1:0] = up;
        3'd1:    rdata_d[N_CH-1:0] = sticky_q;
        3'd2:    rdata_d[N_CH-1:0] = fault;
        3'd4:    rdata_d[15:0]     = rst_len_q;
        3'd5:    rdata_d[N_CH-1:0] = lock_s_q;
`ifdef PLL_LOCK_IRQ_EN
        3'd6:    rdata_d[N_CH-1:0] = mask_q;
`endif
        default: ;
      endcase
    end
  end

  assign avs.avs_readdata = rdata_q;

`ifdef PLL_LOCK_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    mask_d = wr_mask ? avs.avs_writedata[N_CH-1:0] : mask_q;
    irq_d  = |((sticky_q | fault) & mask_q);
  end

  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
module tb_pll_lock_reset_ctrl;
  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_CH-1:0] lock_in = '0;
  logic [N_CH-1:0] rst_out;
`ifdef PLL_LOCK_IRQ_EN
  logic            irq;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_pend = 1'b0;

  pll_lock_reset_ctrl_if bus();

  pll_lock_reset_ctrl #(
    .N_CH(N_CH), .RST_CYCLES(16), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (bus),
    .lock_in(lock_in),
    .rst_out(rst_out)
`ifdef PLL_LOCK_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: reads push an expectation, returned data pops it
  always @(posedge clk) rd_pend <= bus.avs_read;
  always @(negedge clk) begin
    if (rd_pend) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk(tag_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
    end
  end

  task automatic nop();
    @(negedge clk);
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b1;
    bus.avs_address   = a;
    bus.avs_writedata = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
    @(negedge clk);
    bus.avs_write   = 1'b0;
    bus.avs_read    = 1'b1;
    bus.avs_address = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_address = '0; bus.avs_writedata = '0;

    // reset state
    nops(3);
    chk("rst_out_reset", 32'(rst_out), 32'hF);
    chk("rdata_reset", bus.avs_readdata, 32'h0);
    reset_n = 1'b1;
    rd(0, 0, "status0"); rd(1, 0, "sticky0"); rd(2, 0, "fault0"); rd(3, 0, "start0");
    rd(4, 16, "rstlen0"); rd(5, 0, "lockraw0"); rd(6, 0, "mask0"); rd(7, 0, "addr7");
    nop();

    // ch0 full sequence, lock rises as reset falls
    wr(3, 1);
    for (int i = 1; i <= 16; i++) begin
      nop();
      chk("rst0_hi", 32'(rst_out[0]), 32'd1);
    end
    nop();
    chk("rst0_lo", 32'(rst_out[0]), 32'd0);
    chk("rst_others", 32'(rst_out), 32'hE);
    lock_in[0] = 1'b1;
    nops(8);
    rd(0, 0, "status_pre");
    rd(0, 1, "status_up");
    rd(5, 1, "lockraw1");

    // RST_LEN=0 behaves as a 1-cycle pulse
    wr(4, 0);
    wr(3, 2);
    nop(); chk("rst1_len0_hi", 32'(rst_out[1]), 32'd1);
    nop(); chk("rst1_len0_lo", 32'(rst_out[1]), 32'd0);
    lock_in[1] = 1'b1;
    rd(4, 0, "rstlen_zero");
    wr(4, 16);

    // ch2 timeout into FAULT
`ifdef PLL_LOCK_IRQ_EN
    wr(6, 4);
    rd(6, 4, "mask_rd");
`endif
    wr(3, 4);
    nops(17);
    chk("rst2_lo", 32'(rst_out[2]), 32'd0);
    nops(62);
    rd(2, 0, "fault_pre");
    chk("rst2_wait", 32'(rst_out[2]), 32'd0);
    rd(2, 4, "fault_set");
    chk("rst2_fault", 32'(rst_out[2]), 32'd1);
`ifdef PLL_LOCK_IRQ_EN
    chk("irq_pre", 32'(irq), 32'd0);
`endif
    nop();
`ifdef PLL_LOCK_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
`endif
    wr(3, 4);
    lock_in[2] = 1'b1;
    rd(2, 0, "fault_clr");
    chk("rst2_restart", 32'(rst_out[2]), 32'd1);
    nop();
`ifdef PLL_LOCK_IRQ_EN
    chk("irq_clr", 32'(irq), 32'd0);
`endif
    nops(30);
    rd(0, 7, "status_all3");

    // single-cycle loss of lock on ch0
    nop(); lock_in[0] = 1'b0;
    nop(); lock_in[0] = 1'b1;
    nop(); chk("loss_rst_pre", 32'(rst_out[0]), 32'd0);
    rd(1, 1, "sticky_set");
    chk("loss_rst", 32'(rst_out[0]), 32'd1);
    rd(0, 6, "status_loss");
    wr(1, 1);
    rd(1, 0, "sticky_w1c");

    // W1C coinciding with a fresh loss: set wins
    wr(3, 1);
    nops(40);
    rd(0, 7, "status_re");
    nop(); lock_in[0] = 1'b0;
    nop(); lock_in[0] = 1'b1;
    wr(1, 1);
    rd(1, 1, "sticky_setwins");

    // START coinciding with loss on ch1: RESET entered, STICKY still set
    nop(); lock_in[1] = 1'b0;
    nop(); lock_in[1] = 1'b1;
    wr(3, 2);
    rd(1, 3, "sticky_start_loss");
    chk("rst1_restart", 32'(rst_out[1]), 32'd1);
    nops(15);
    chk("rst1_seq_hi", 32'(rst_out[1]), 32'd1);
    nop();
    chk("rst1_seq_lo", 32'(rst_out[1]), 32'd0);

    // asynchronous reset mid-sequence
    wr(3, 1);
    nops(3);
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(rst_out), 32'hF);
    chk("async_rdata", bus.avs_readdata, 32'h0);
`ifdef PLL_LOCK_IRQ_EN
    chk("async_irq", 32'(irq), 32'd0);
`endif
    nops(2);
    reset_n = 1'b1;
    rd(1, 0, "sticky_after_rst");
    rd(0, 0, "status_after_rst");
    rd(4, 16, "rstlen_after_rst");
    nops(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pll_lock_reset_ctrl.md
# pll_lock_reset_ctrl

Parametrised per-channel PLL reset sequencer and lock monitor for the TDC sensor SoC. It replaces the fixed 32-bit reset/lock PIO pairs with one Avalon-MM slave that drives N PLL reset lines and sequences each channel autonomously: timed reset pulse, lock qualification, timeout fault and sticky loss-of-lock. It sits on the Nios V peripheral bus next to the theta/phi clock PLLs.

## Interface
- N_CH, 4: number of PLL channels, 1..32
- RST_CYCLES, 16: reset value of RST_LEN register
- STABLE_CYCLES, 8: consecutive synchronised lock-high cycles required to declare lock, 1..255
- TIMEOUT_CYCLES, 4096: cycles allowed in WAIT before FAULT, 2..2^20
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- lock_in  in  N_CH  asynchronous PLL locked inputs
- rst_out  out  N_CH  active-high PLL reset, one per channel
- irq  out  1  level interrupt (only with PLL_LOCK_IRQ_EN)

## Operation
- lock_in passes a 2-flop synchroniser per bit, giving lock_s.
- Registers; bits above N_CH read 0, ignore writes:
  - 0 STATUS RO: [N_CH-1:0] = channel state is UP.
  - 1 STICKY W1C: loss-of-lock seen in UP.
  - 2 FAULT RO: channel state is FAULT.
  - 3 START WO: writing 1 to bit i starts a sequence on channel i; reads 0.
  - 4 RST_LEN RW: [15:0] reset pulse length; 0 is treated as 1.
  - 5 LOCK_RAW RO: lock_s.
  - 6 IRQ_MASK RW (macro only; otherwise reads 0).
  - 7 reads 0.
- Per-channel FSM: IDLE, RESET, WAIT, UP, FAULT.
  - IDLE: rst_out=1. START -> RESET.
  - RESET: rst_out=1; 16-bit counter; after RST_LEN cycles in RESET -> WAIT.
  - WAIT: rst_out=0; stable counter increments while lock_s=1, clears when 0; reaching STABLE_CYCLES -> UP. Timeout counter reaching TIMEOUT_CYCLES -> FAULT, rst_out=1.
  - UP: rst_out=0. lock_s=0 -> set STICKY[i], go IDLE.
  - FAULT: rst_out=1; holds until START.
- START in any state restarts at RESET with counters cleared; RST_LEN is sampled on entry to RESET.
- Simultaneous: STICKY set and W1C clear of same bit -> set wins. START with loss in UP -> RESET, STICKY still set. Timeout and stable completion in same cycle -> UP.

## Timing
- Reset values: rst_out all 1, every FSM in IDLE, STICKY/FAULT 0, RST_LEN=RST_CYCLES, IRQ_MASK 0, avs_readdata 0, irq 0.
- START written at cycle T: RESET from T+1; rst_out high for exactly RST_LEN cycles T+1..T+RST_LEN; low at T+RST_LEN+1.
- lock_in to lock_s: 2 cycles. UP is entered STABLE_CYCLES cycles after the first qualifying lock_s=1 cycle in WAIT.
- Loss in UP: lock_in drop at cycle T gives STICKY set and rst_out=1 at T+3.
- Read latency is 1 cycle. No waitrequest. Writes take effect the next cycle.
- reset_n assertion mid-sequence aborts at once to the reset values.

## Configuration
- PLL_LOCK_IRQ_EN defined: IRQ_MASK register and irq port exist. irq = |((STICKY | FAULT) & IRQ_MASK), registered, 1-cycle latency.
- PLL_LOCK_IRQ_EN undefined: no irq port, address 6 reads 0, no interrupt logic.

## Test plan
- Default params, reset_n released, lock_in=0 -> rst_out=4'hF, STATUS=0, all registers at reset values.
- START=4'h1, lock_in[0] high throughout -> rst_out[0] high 16 cycles then low; STATUS=1 exactly 2+8 cycles after rst_out[0] falls.
- RST_LEN=0, START ch1 -> rst_out[1] high exactly 1 cycle.
- START ch2, lock_in[2]=0, TIMEOUT_CYCLES=64 -> FAULT=4'h4 after 64 WAIT cycles, rst_out[2]=1; a new START clears FAULT.
- Ch0 in UP, lock_in[0] pulsed low 1 cycle -> STICKY=1, rst_out[0]=1, ch0 in IDLE; W1C write of 1 in the same cycle as a new loss leaves STICKY=1.
- With PLL_LOCK_IRQ_EN, IRQ_MASK=4'h4, ch2 times out -> irq=1 one cycle after FAULT[2] sets; START ch2 drops irq.
